// File: rtl/com_pkg.sv
// Shared types and field widths for the com transmit arbiter.
package com_pkg;

    localparam int unsigned BTYPE_W = 4;
    localparam int unsigned DLEN_W  = 12;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned GRANT_W = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StSend   = 3'd2,
        StWaitLo = 3'd3,
        StGapW   = 3'd4,
        StDone   = 3'd5
    } state_t;

endpackage

// File: rtl/com_rr_pick.sv
// Combinational round-robin picker: lowest distance from the slot after the last winner wins.
module com_rr_pick
    import com_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [GRANT_W-1:0] i_last,
    output logic [GRANT_W-1:0] o_grant,
    output logic               o_valid
);

    int unsigned w_dist;
    int unsigned w_best;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // i_last <= NREQ-1, so the subtraction never wraps
            w_dist = (i + NREQ - 1 - 32'(i_last)) % NREQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_grant = GRANT_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_arb.sv
// Round-robin send arbiter in front of the com transmit interface, with bounded retry
// on transmit error or timeout and a per-requester done/error handshake.
module com_arb
    import com_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned GAP       = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_fs,
    input  logic [BTYPE_W*NREQ-1:0] i_req_btype,
    input  logic [DLEN_W*NREQ-1:0]  i_req_dlen,
    input  logic [ADDR_W*NREQ-1:0]  i_req_addr,
    output logic [NREQ-1:0]         o_req_fd,
    output logic [NREQ-1:0]         o_req_er,
    output logic                    o_fs_send,
    output logic [BTYPE_W-1:0]      o_send_btype,
    output logic [DLEN_W-1:0]       o_send_dlen,
    output logic [ADDR_W-1:0]       o_ram_addr_init,
    input  logic                    i_fd_send,
    input  logic                    i_fd_txer,
    output logic                    o_busy,
    output logic [GRANT_W-1:0]      o_grant
);

    localparam int unsigned          RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [15:0]          TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0]          GAP_LAST  = 16'(GAP - 1);
    localparam logic [GRANT_W-1:0]   LAST_RST  = GRANT_W'(NREQ - 1);

    state_t               r_state, w_state_d;
    logic [NREQ-1:0]      r_req_fd, w_req_fd_d, r_req_er, w_req_er_d;
    logic                 r_fs_send, r_busy, r_err, w_err_d;
    logic [BTYPE_W-1:0]   r_btype, w_btype_d;
    logic [DLEN_W-1:0]    r_dlen, w_dlen_d;
    logic [ADDR_W-1:0]    r_addr, w_addr_d;
    logic [GRANT_W-1:0]   r_grant, w_grant_d, r_last, w_last_d;
    logic [RETRY_W-1:0]   r_retry, w_retry_d;
    logic [15:0]          r_tmo, w_tmo_d, r_gap, w_gap_d;

    logic [NREQ-1:0]      w_onehot;
    logic [BTYPE_W-1:0]   w_win_btype;
    logic [DLEN_W-1:0]    w_win_dlen;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [GRANT_W-1:0]   w_pick_grant;
    logic                 w_pick_valid, w_gnt_fs, w_flags_low, w_abort, w_retry_more;

    com_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (i_req_fs & ~r_req_fd),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_onehot    = '0;
        w_win_btype = '0;
        w_win_dlen  = '0;
        w_win_addr  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_grant == GRANT_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_win_btype = i_req_btype[i*BTYPE_W +: BTYPE_W];
                w_win_dlen  = i_req_dlen[i*DLEN_W +: DLEN_W];
                w_win_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_gnt_fs     = |(i_req_fs & w_onehot);
    assign w_flags_low  = !i_fd_send && !i_fd_txer;
    assign w_abort      = i_fd_txer || (r_tmo == TMO_LAST);
    assign w_retry_more = r_err && (r_retry < RETRY_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (w_pick_valid) w_state_d = StLoad;
            StLoad:   w_state_d = StSend;
            StSend:   if (w_abort || i_fd_send) w_state_d = StWaitLo;
            StWaitLo: if (w_flags_low) w_state_d = w_retry_more ? StGapW : StDone;
            StGapW:   if (r_gap == GAP_LAST) w_state_d = StSend;
            StDone:   if (!w_gnt_fs) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_grant_d  = r_grant;
        w_last_d   = r_last;
        w_btype_d  = r_btype;
        w_dlen_d   = r_dlen;
        w_addr_d   = r_addr;
        w_retry_d  = r_retry;
        w_tmo_d    = r_tmo;
        w_gap_d    = r_gap;
        w_err_d    = r_err;
        w_req_fd_d = r_req_fd;
        w_req_er_d = r_req_er;
        case (r_state)
            StIdle: if (w_pick_valid) w_grant_d = w_pick_grant;
            StLoad: begin
                w_btype_d = w_win_btype;
                w_dlen_d  = w_win_dlen;
                w_addr_d  = w_win_addr;
                w_retry_d = '0;
                w_tmo_d   = '0;
            end
            StSend: begin
                w_tmo_d = (r_tmo == 16'hFFFF) ? r_tmo : r_tmo + 16'd1;
                // txer wins over a simultaneous fd_send
                if (w_abort)        w_err_d = 1'b1;
                else if (i_fd_send) w_err_d = 1'b0;
            end
            StWaitLo: begin
                if (w_flags_low) begin
                    if (w_retry_more) begin
                        w_retry_d = r_retry + RETRY_W'(1);
                        w_gap_d   = '0;
                    end else begin
                        w_req_fd_d = w_onehot;
                        w_req_er_d = w_onehot & {NREQ{r_err}};
                    end
                end
            end
            StGapW: begin
                w_gap_d = r_gap + 16'd1;
                w_tmo_d = '0;
            end
            StDone: begin
                if (!w_gnt_fs) begin
                    w_req_fd_d = '0;
                    w_req_er_d = '0;
                    w_last_d   = r_grant;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fs_send <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_req_fd  <= '0;
            r_req_er  <= '0;
            r_btype   <= '0;
            r_dlen    <= '0;
            r_addr    <= '0;
            r_grant   <= '0;
            r_last    <= LAST_RST;
            r_retry   <= '0;
            r_tmo     <= '0;
            r_gap     <= '0;
        end else begin
            r_fs_send <= (w_state_d == StSend);
            r_busy    <= (w_state_d != StIdle);
            r_err     <= w_err_d;
            r_req_fd  <= w_req_fd_d;
            r_req_er  <= w_req_er_d;
            r_btype   <= w_btype_d;
            r_dlen    <= w_dlen_d;
            r_addr    <= w_addr_d;
            r_grant   <= w_grant_d;
            r_last    <= w_last_d;
            r_retry   <= w_retry_d;
            r_tmo     <= w_tmo_d;
            r_gap     <= w_gap_d;
        end
    end

    assign o_fs_send       = r_fs_send;
    assign o_busy          = r_busy;
    assign o_req_fd        = r_req_fd;
    assign o_req_er        = r_req_er;
    assign o_send_btype    = r_btype;
    assign o_send_dlen     = r_dlen;
    assign o_ram_addr_init = r_addr;
    assign o_grant         = r_grant;

endmodule

// File: tb/tb_com_arb.sv
// Self-checking bench for com_arb: scenario tasks plus randomized transfers against a
// behavioural round-robin / retry-outcome model.
module tb_com_arb;

    localparam int NREQ = 4, MAX_RETRY = 3, TIMEOUT = 100, GAP = 16;
    localparam int K_SEND = 0, K_TXER = 1, K_BOTH = 2, K_SILENT = 3;

    typedef struct {
        int kind;
        int delay;
    } rsp_t;

    logic        clk, rst_n;
    logic [3:0]  req_fs;
    logic [15:0] req_btype;
    logic [47:0] req_dlen, req_addr;
    logic [3:0]  req_fd, req_er;
    logic        fs_send, fd_send, fd_txer, busy;
    logic [3:0]  send_btype;
    logic [11:0] send_dlen, ram_addr_init;
    logic [2:0]  grant;

    com_arb #(
        .NREQ      (NREQ),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT),
        .GAP       (GAP)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_fs        (req_fs),
        .i_req_btype     (req_btype),
        .i_req_dlen      (req_dlen),
        .i_req_addr      (req_addr),
        .o_req_fd        (req_fd),
        .o_req_er        (req_er),
        .o_fs_send       (fs_send),
        .o_send_btype    (send_btype),
        .o_send_dlen     (send_dlen),
        .o_ram_addr_init (ram_addr_init),
        .i_fd_send       (fd_send),
        .i_fd_txer       (fd_txer),
        .o_busy          (busy),
        .o_grant         (grant)
    );

    int          n_checks = 0, n_errors = 0;
    int          cyc = 0, t_req = 0, m_last = NREQ - 1;
    int          rise_q[$], fall_q[$], drop_q[$];
    logic [27:0] snd_q[$];
    rsp_t        rsp_q[$];
    logic        prev_fs = 1'b0;
    logic [3:0]  d_btype[4];
    logic [11:0] d_dlen[4], d_addr[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (fs_send === 1'b1 && prev_fs === 1'b0) begin
            rise_q.push_back(cyc);
            snd_q.push_back({send_btype, send_dlen, ram_addr_init});
        end
        if (fs_send === 1'b0 && prev_fs === 1'b1) fall_q.push_back(cyc);
        prev_fs = fs_send;
    end

    // com model: answers each fs_send with the next queued response, then holds flags
    // until fs_send drops (four-phase)
    initial begin
        rsp_t r;
        fd_send = 1'b0;
        fd_txer = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (fs_send === 1'b1) begin
                if (rsp_q.size() > 0) r = rsp_q.pop_front();
                else begin
                    r.kind  = K_SILENT;
                    r.delay = 0;
                end
                for (int k = 0; k < r.delay && fs_send === 1'b1; k++) begin
                    @(posedge clk); #1;
                end
                if (fs_send === 1'b1) begin
                    fd_send = (r.kind == K_SEND) || (r.kind == K_BOTH);
                    fd_txer = (r.kind == K_TXER) || (r.kind == K_BOTH);
                end
                for (int k = 0; k < 300 && fs_send === 1'b1; k++) begin
                    @(posedge clk); #1;
                end
                fd_send = 1'b0;
                fd_txer = 1'b0;
                drop_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int model_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (req[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // first successful attempt ends the transfer; otherwise MAX_RETRY+1 attempts then ERR
    function automatic void model_outcome(input int kinds[4], output int pulses, output bit er);
        pulses = MAX_RETRY + 1;
        er     = 1'b1;
        for (int k = MAX_RETRY; k >= 0; k--) begin
            if (kinds[k] == K_SEND) begin
                pulses = k + 1;
                er     = 1'b0;
            end
        end
    endfunction

    task automatic load_data();
        for (int i = 0; i < NREQ; i++) begin
            req_btype[i*4 +: 4]  = d_btype[i];
            req_dlen[i*12 +: 12] = d_dlen[i];
            req_addr[i*12 +: 12] = d_addr[i];
        end
    endtask

    task automatic run_txn(input logic [3:0] reqs, output int g, output bit ok);
        rise_q.delete();
        fall_q.delete();
        drop_q.delete();
        snd_q.delete();
        @(posedge clk); #1;
        req_fs = reqs;
        t_req  = cyc;
        ok     = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (req_fd !== 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        g = int'(grant);
    endtask

    task automatic release_all();
        @(posedge clk); #1;
        req_fs = 4'b0;
        rsp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_fs = '0;
        rsp_q.delete();
        repeat (3) @(negedge clk);
        n_checks += 8;
        if (fs_send !== 1'b0) begin n_errors++; $display("FAIL reset_fs_send got %0b want 0", fs_send); end
        if (req_fd !== 4'b0) begin n_errors++; $display("FAIL reset_req_fd got %0h want 0", req_fd); end
        if (req_er !== 4'b0) begin n_errors++; $display("FAIL reset_req_er got %0h want 0", req_er); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        if (send_btype !== 4'h0) begin n_errors++; $display("FAIL reset_btype got %0h want 0", send_btype); end
        if (send_dlen !== 12'h0) begin n_errors++; $display("FAIL reset_dlen got %0h want 0", send_dlen); end
        if (ram_addr_init !== 12'h0) begin n_errors++; $display("FAIL reset_addr got %0h want 0", ram_addr_init); end
        if (grant !== 3'd0) begin n_errors++; $display("FAIL reset_grant got %0d want 0", grant); end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_clean_transfer();
        int g, exp_g;
        bit ok;
        d_btype[2] = 4'h3; d_dlen[2] = 12'h040; d_addr[2] = 12'h100;
        load_data();
        rsp_q.push_back('{K_SEND, 70});
        exp_g = model_pick(4'b0100, m_last);
        run_txn(4'b0100, g, ok);
        n_checks += 6;
        if (!ok) begin n_errors++; $display("FAIL clean_done timeout got 0 want 1"); end
        if (g != exp_g) begin n_errors++; $display("FAIL clean_grant got %0d want %0d", g, exp_g); end
        if (rise_q.size() != 1 || rise_q[0] - t_req != 2) begin
            n_errors++;
            $display("FAIL clean_latency got %0d pulses first at +%0d want 1 at +2", rise_q.size(),
                     rise_q.size() > 0 ? rise_q[0] - t_req : -1);
        end
        if (snd_q.size() < 1 || snd_q[0] !== {4'h3, 12'h040, 12'h100}) begin
            n_errors++;
            $display("FAIL clean_send_fields got %h want %h", snd_q.size() > 0 ? snd_q[0] : 28'hx,
                     {4'h3, 12'h040, 12'h100});
        end
        if (req_fd !== 4'b0100) begin n_errors++; $display("FAIL clean_req_fd got %b want 0100", req_fd); end
        if (req_er !== 4'b0000) begin n_errors++; $display("FAIL clean_req_er got %b want 0000", req_er); end
        if (ok) m_last = exp_g;
        release_all();
        n_checks += 2;
        if (req_fd !== 4'b0) begin n_errors++; $display("FAIL clean_fd_clear got %b want 0000", req_fd); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL clean_idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] pats[7];
        int g, exp_g;
        bit ok;
        pats = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010, 4'b1010};
        for (int r = 0; r < 7; r++) begin
            rsp_q.push_back('{K_SEND, 2});
            exp_g = model_pick(pats[r], m_last);
            run_txn(pats[r], g, ok);
            n_checks++;
            if (!ok || g != exp_g) begin
                n_errors++;
                $display("FAIL rr_grant round %0d got %0d (done=%0b) want %0d", r, g, ok, exp_g);
            end
            if (ok) m_last = exp_g;
            release_all();
        end
    endtask

    task automatic test_err_then_ok();
        int g, exp_g;
        bit ok;
        logic [27:0] exp_s;
        d_btype[1] = 4'h9; d_dlen[1] = 12'h3A5; d_addr[1] = 12'h7C2;
        load_data();
        exp_s = {4'h9, 12'h3A5, 12'h7C2};
        rsp_q.push_back('{K_TXER, 3});
        rsp_q.push_back('{K_SEND, 5});
        exp_g = model_pick(4'b0010, m_last);
        run_txn(4'b0010, g, ok);
        n_checks += 5;
        if (!ok || g != exp_g) begin n_errors++; $display("FAIL retry1_grant got %0d want %0d", g, exp_g); end
        if (rise_q.size() != 2) begin n_errors++; $display("FAIL retry1_pulses got %0d want 2", rise_q.size()); end
        if (rise_q.size() < 2 || drop_q.size() < 1 || rise_q[1] - drop_q[0] != GAP + 1) begin
            n_errors++;
            $display("FAIL retry1_gap got %0d want %0d",
                     (rise_q.size() > 1 && drop_q.size() > 0) ? rise_q[1] - drop_q[0] : -1, GAP + 1);
        end
        if (req_er !== 4'b0) begin n_errors++; $display("FAIL retry1_req_er got %b want 0000", req_er); end
        if (snd_q.size() < 2 || snd_q[0] !== exp_s || snd_q[1] !== exp_s) begin
            n_errors++;
            $display("FAIL retry1_send_stable got %0d records want both %h", snd_q.size(), exp_s);
        end
        if (ok) m_last = exp_g;
        release_all();
    endtask

    task automatic test_retry_exhaust();
        int g, exp_g;
        bit ok;
        for (int k = 0; k < 4; k++) rsp_q.push_back('{K_TXER, 1});
        exp_g = model_pick(4'b1000, m_last);
        run_txn(4'b1000, g, ok);
        n_checks += 3;
        if (rise_q.size() != 4) begin n_errors++; $display("FAIL exhaust_pulses got %0d want 4", rise_q.size()); end
        if (req_fd !== 4'b1000) begin n_errors++; $display("FAIL exhaust_req_fd got %b want 1000", req_fd); end
        if (req_er !== 4'b1000) begin n_errors++; $display("FAIL exhaust_req_er got %b want 1000", req_er); end
        if (ok) m_last = exp_g;
        release_all();
    endtask

    task automatic test_timeout();
        int g, exp_g;
        bit ok;
        exp_g = model_pick(4'b0001, m_last);
        run_txn(4'b0001, g, ok);
        n_checks += 3;
        if (rise_q.size() != 4) begin n_errors++; $display("FAIL tmo_pulses got %0d want 4", rise_q.size()); end
        if (rise_q.size() < 1 || fall_q.size() < 1 || fall_q[0] - rise_q[0] != TIMEOUT) begin
            n_errors++;
            $display("FAIL tmo_width got %0d want %0d",
                     (rise_q.size() > 0 && fall_q.size() > 0) ? fall_q[0] - rise_q[0] : -1, TIMEOUT);
        end
        if (req_er !== 4'b0001) begin n_errors++; $display("FAIL tmo_req_er got %b want 0001", req_er); end
        if (ok) m_last = exp_g;
        release_all();
    endtask

    task automatic test_simultaneous();
        int g, exp_g;
        bit ok;
        rsp_q.push_back('{K_BOTH, 2});
        rsp_q.push_back('{K_SEND, 2});
        exp_g = model_pick(4'b0100, m_last);
        run_txn(4'b0100, g, ok);
        n_checks += 2;
        if (rise_q.size() != 2) begin n_errors++; $display("FAIL both_pulses got %0d want 2", rise_q.size()); end
        if (req_er !== 4'b0 || req_fd !== 4'b0100) begin
            n_errors++;
            $display("FAIL both_result got fd=%b er=%b want fd=0100 er=0000", req_fd, req_er);
        end
        if (ok) m_last = exp_g;
        release_all();
    endtask

    task automatic test_reset_mid_send();
        bit seen;
        d_btype[1] = 4'hA; d_dlen[1] = 12'h5A5; d_addr[1] = 12'hC3C;
        load_data();
        @(posedge clk); #1;
        req_fs = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (fs_send === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (!seen) begin n_errors++; $display("FAIL rstmid_send_start got 0 want 1"); end
        if (fs_send !== 1'b0) begin n_errors++; $display("FAIL rstmid_fs_send got %0b want 0", fs_send); end
        if (busy !== 1'b0 || req_fd !== 4'b0 || req_er !== 4'b0) begin
            n_errors++;
            $display("FAIL rstmid_flags got busy=%0b fd=%b er=%b want all 0", busy, req_fd, req_er);
        end
        if ({send_btype, send_dlen, ram_addr_init} !== 28'h0) begin
            n_errors++;
            $display("FAIL rstmid_send_fields got %h want 0", {send_btype, send_dlen, ram_addr_init});
        end
        if (grant !== 3'd0) begin n_errors++; $display("FAIL rstmid_grant got %0d want 0", grant); end
        req_fs = 4'b0;
        rsp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int g, exp_g, exp_p, kinds[4];
        bit ok, exp_er;
        logic [3:0] reqs, exp_oh;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                d_btype[i] = 4'($urandom);
                d_dlen[i]  = 12'($urandom);
                d_addr[i]  = 12'($urandom);
            end
            load_data();
            reqs = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) begin
                int sel;
                sel = int'($urandom_range(0, 3));
                kinds[k] = (sel < 2) ? K_SEND : ((sel == 2) ? K_TXER : K_BOTH);
                rsp_q.push_back('{kinds[k], int'($urandom_range(0, 6))});
            end
            exp_g = model_pick(reqs, m_last);
            model_outcome(kinds, exp_p, exp_er);
            exp_oh = 4'b0001 << exp_g;
            run_txn(reqs, g, ok);
            n_checks += 4;
            if (!ok || g != exp_g || req_fd !== exp_oh) begin
                n_errors++;
                $display("FAIL rand_grant it %0d got g=%0d fd=%b want g=%0d fd=%b", it, g, req_fd,
                         exp_g, exp_oh);
            end
            if (rise_q.size() != exp_p) begin
                n_errors++;
                $display("FAIL rand_pulses it %0d got %0d want %0d", it, rise_q.size(), exp_p);
            end
            if (req_er !== (exp_er ? exp_oh : 4'b0)) begin
                n_errors++;
                $display("FAIL rand_req_er it %0d got %b want %b", it, req_er, exp_er ? exp_oh : 4'b0);
            end
            if (snd_q.size() < 1 || snd_q[snd_q.size()-1] !== {d_btype[exp_g], d_dlen[exp_g], d_addr[exp_g]}) begin
                n_errors++;
                $display("FAIL rand_send_fields it %0d want %h", it,
                         {d_btype[exp_g], d_dlen[exp_g], d_addr[exp_g]});
            end
            if (ok) m_last = exp_g;
            release_all();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_fs = '0;
        req_btype = '0;
        req_dlen = '0;
        req_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            d_btype[i] = '0;
            d_dlen[i]  = '0;
            d_addr[i]  = '0;
        end
        test_reset();
        test_clean_transfer();
        test_round_robin();
        test_err_then_ok();
        test_retry_exhaust();
        test_timeout();
        test_simultaneous();
        test_reset_mid_send();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/com_arb.md
# com_arb

Round-robin send arbiter in front of the `com` transmit interface. It lets NREQ independent producers (sample uplink, command ack, heartbeat, …) share the single `fs_send`/`fd_send` channel. It latches the winner's block type, length and RAM start address, and runs the four-phase flag handshake with `com`. Transmit errors and timeouts trigger a bounded retry, and each requester gets a per-requester done/error result.

## Interface
- NREQ, 4 — number of requesters (2..8)
- MAX_RETRY, 3 — retries after the first attempt before reporting error
- TIMEOUT, 65535 — clk cycles in SEND without `fd_send`/`fd_txer` before an abort
- GAP, 16 — idle cycles between an error and the retry
- clk  in  1  system clock (same domain as `com` `sys_clk`)
- rst  in  1  asynchronous, active-low reset
- req_fs  in  NREQ  per-requester send request (level, four-phase)
- req_btype  in  4*NREQ  block type; slice i = [4i+3:4i]
- req_dlen  in  12*NREQ  byte length; slice i = [12i+11:12i]
- req_addr  in  12*NREQ  RAM start address; slice i = [12i+11:12i]
- req_fd  out  NREQ  per-requester done flag
- req_er  out  NREQ  per-requester error flag; valid while `req_fd` is high
- fs_send  out  1  to `com`
- send_btype  out  4  to `com`
- send_dlen  out  12  to `com`
- ram_addr_init  out  12  to `com`
- fd_send  in  1  from `com`, transfer complete
- fd_txer  in  1  from `com`, transfer error
- busy  out  1  high in every state except IDLE
- grant  out  3  index of the current or last winner

## Operation
- States: IDLE, LOAD, SEND, WAITLO, GAPW, DONE.
- **IDLE:** if any `req_fs[i]` is high and `req_fd[i]` is low, pick a winner by round-robin, starting at (last winner + 1) mod NREQ. Go to LOAD.
- **LOAD:**
  - Register the winner's btype, dlen and addr into `send_*`.
  - Clear `retry_cnt` and `tmo_cnt`.
  - Go to SEND.
  - `send_*` stay stable from LOAD until the next LOAD.
- **SEND:**
  - `fs_send` = 1, and `tmo_cnt` increments.
  - `fd_txer` = 1 (it has priority over a simultaneous `fd_send`), or `tmo_cnt` == TIMEOUT-1: set `err_flag`, go to WAITLO.
  - Otherwise `fd_send` = 1: clear `err_flag`, go to WAITLO.
- **WAITLO:** `fs_send` = 0. Stay until `fd_send` and `fd_txer` are both low. Then:
  - no error: go to DONE with result OK;
  - error and `retry_cnt` < MAX_RETRY: increment `retry_cnt`, go to GAPW;
  - error and `retry_cnt` == MAX_RETRY: go to DONE with result ERR.
- **GAPW:** count GAP cycles, clear `tmo_cnt`, return to SEND. `send_*` are not reloaded.
- **DONE:**
  - `req_fd[g]` = 1 and `req_er[g]` = result.
  - When `req_fs[g]` falls, clear `req_fd[g]` and `req_er[g]` and go to IDLE.
  - `last` = g.
- A requester that drops `req_fs` while it is granted is ignored until DONE. The transfer always completes or fails first.
- A requester whose `req_fd` is still high is not eligible for a new grant.
- Only one `req_fd` bit is high at a time.

## Timing
- Reset values:
  - FSM is in IDLE.
  - `fs_send`, `req_fd`, `req_er`, `busy` are 0.
  - `send_btype`, `send_dlen`, `ram_addr_init`, `grant` are 0.
  - Counters are 0 and `last` = NREQ-1, so requester 0 wins first after reset.
- All outputs are registered.
- Latency from `req_fs` rising to `fs_send` rising is 2 cycles: IDLE→LOAD, then LOAD→SEND.
- `fs_send` falls on the cycle after `fd_send` or `fd_txer` is sampled high.
- `req_fd` rises 1 cycle after WAITLO sees both flags low.
- Earliest re-grant is 1 cycle after `req_fs[g]` falls.
- Retry spacing: from `fd_txer` low to `fs_send` high is GAP+1 cycles.
- Timeout counter is 16 bits and saturates. It is compared against TIMEOUT-1.
- `fd_send` and `fd_txer` are assumed to be in the clk domain, as the `com_cs` outputs are.
- Reset asserted mid-transfer drops `fs_send` immediately (asynchronously). `com` must see `fs_send` low as an abort.

## Structure
- Shared package `com_pkg`:
  - state encoding localparams;
  - widths BTYPE_W = 4, DLEN_W = 12, ADDR_W = 12.
- One sub-module, `com_rr_pick`: combinational round-robin priority encoder (req vector, last → grant index, valid).
- The remainder is the FSM and counters in `com_arb`.

## Test plan
- **Single request, clean transfer:**
  - Stimulus: `req_fs[2]`=1 with btype 4'h3, dlen 12'h040, addr 12'h100; `com` model returns `fd_send` after 70 cycles.
  - Required: `fs_send` rises 2 cycles after `req_fs[2]`, with btype 3, dlen 0x040, addr 0x100.
  - Then `req_fd[2]`=1 and `req_er[2]`=0; clears 1 cycle after `req_fs[2]` drops.
- **Round-robin fairness:**
  - Stimulus: `req_fs` = 4'b1111 held and re-raised immediately after each DONE.
  - Required: grant order 0,1,2,3,0.
  - With `req_fs` = 4'b1010 after winner 1, the next winner is 3.
- **Single error then success:**
  - Stimulus: first attempt answered with `fd_txer`, second with `fd_send`.
  - Required: exactly two `fs_send` pulses, separated by GAP+1 cycles after `fd_txer` falls; `req_er`=0; `send_*` unchanged between attempts.
- **Retry exhaustion:**
  - Stimulus: `fd_txer` on every attempt, MAX_RETRY=3.
  - Required: 4 `fs_send` pulses, then `req_fd[g]`=1 with `req_er[g]`=1.
- **Timeout:**
  - Stimulus: TIMEOUT=100, `com` never responds.
  - Required: `fs_send` drops after 100 cycles high and the arbiter retries.
  - After 4 attempts, ERR is reported.
- **Reset mid-SEND and simultaneous flags:**
  - Stimulus: `rst` low during SEND.
  - Required: `fs_send`=0 asynchronously and all outputs at reset values.
  - Stimulus: `fd_send` and `fd_txer` high in the same cycle.
  - Required: treated as an error, and a retry occurs.
